// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the multi-cycle mini CPU: opcodes,
// instruction field positions and the sequencing FSM states.
package mini_cpu_pkg;

   localparam int INSTR_W = 18;
   localparam int REG_AW  = 4;

   localparam int OP_HI  = 17;
   localparam int OP_LO  = 15;
   localparam int DST_HI = 14;
   localparam int DST_LO = 11;
   localparam int S1_HI  = 10;
   localparam int S1_LO  = 7;
   localparam int S2_HI  = 6;
   localparam int S2_LO  = 3;

   localparam logic [2:0] OP_LOAD    = 3'b000;
   localparam logic [2:0] OP_ADD     = 3'b001;
   localparam logic [2:0] OP_ADDI    = 3'b010;
   localparam logic [2:0] OP_SUB     = 3'b011;
   localparam logic [2:0] OP_SUBI    = 3'b100;
   localparam logic [2:0] OP_MUL     = 3'b101;
   localparam logic [2:0] OP_CLEAR   = 3'b110;
   localparam logic [2:0] OP_DISPLAY = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MUL_ITER,
      S_CLR_ITER,
      S_WRITE
   } state_t;

endpackage

// File: rtl/mini_cpu_regfile.sv
// NREGS x DATA_W register file: one write port, two combinational
// read ports, and a per-index clear used by the CLEAR sequence.
module mini_cpu_regfile
   import mini_cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              we,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (clr_en && clr_idx == REG_AW'(i))
               regs[i] <= '0;
            else if (we && wr_addr == REG_AW'(i))
               regs[i] <= wr_data;
         end
      end
   end

   // Out-of-range addresses read as zero
   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (rd_addr_a == REG_AW'(i)) rd_data_a = regs[i];
         if (rd_addr_b == REG_AW'(i)) rd_data_b = regs[i];
      end
   end

endmodule

// File: rtl/mini_cpu_core.sv
// Multi-cycle mini CPU core with iterative shift-add multiplier.
// Define MINI_CPU_SATURATE_EN to clamp on signed overflow instead of wrapping.
module mini_cpu_core
   import mini_cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16,
   parameter int IMM_W  = 7
) (
   input  logic               CLOCK_50,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [DATA_W-1:0]  result,
   output logic [REG_AW-1:0]  result_dest,
   output logic [2:0]         result_op,
   output logic               result_valid,
   output logic               busy,
   output logic               err
);

   localparam logic [4:0] LAST_MUL = 5'(DATA_W - 1);
   localparam logic [4:0] LAST_CLR = 5'(NREGS - 1);
   localparam logic [4:0] NR_LIM   = 5'(NREGS);
   localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

   state_t state, state_nx;

   logic [INSTR_W-1:0]  ir;
   logic [2:0]          op;
   logic [REG_AW-1:0]   dst, src1, src2;
   logic [DATA_W-1:0]   imm_ext;
   logic [DATA_W-1:0]   rd_data_a, rd_data_b;
   logic [REG_AW-1:0]   rd_addr_a;
   logic                use_imm, bad;
   logic [DATA_W-1:0]   a_q, b_q, res_q;
   logic                ovf_q, bad_q;
   logic [2*DATA_W-1:0] acc, mcand;
   logic [DATA_W-1:0]   mplier;
   logic [4:0]          cnt;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_ovf;
   logic [DATA_W:0]     mul_hi;
   logic                mul_ovf;
   logic [DATA_W-1:0]   wb_raw, wb_val;
   logic                wb_ovf, wb_neg, we;

   assign op      = ir[OP_HI:OP_LO];
   assign dst     = ir[DST_HI:DST_LO];
   assign src1    = ir[S1_HI:S1_LO];
   assign src2    = ir[S2_HI:S2_LO];
   assign imm_ext = DATA_W'(signed'(ir[IMM_W-1:0]));

   assign instr_ready = (state == S_IDLE);
   assign busy        = (state != S_IDLE);

   function automatic logic in_range(input logic [REG_AW-1:0] a);
      return {1'b0, a} < NR_LIM;
   endfunction

   always_comb begin
      bad = 1'b0;
      case (op)
         OP_ADD, OP_SUB:
            bad = !in_range(dst) || !in_range(src1) || !in_range(src2);
         OP_ADDI, OP_SUBI, OP_MUL:
            bad = !in_range(dst) || !in_range(src1);
         OP_LOAD, OP_DISPLAY:
            bad = !in_range(dst);
         default: bad = 1'b0;
      endcase
   end

   assign use_imm   = (op == OP_LOAD) || (op == OP_ADDI) ||
                      (op == OP_SUBI) || (op == OP_MUL);
   assign rd_addr_a = (op == OP_DISPLAY) ? dst : src1;

   mini_cpu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .CLOCK_50  (CLOCK_50),
      .rst_n     (rst_n),
      .rd_addr_a (rd_addr_a),
      .rd_data_a (rd_data_a),
      .rd_addr_b (src2),
      .rd_data_b (rd_data_b),
      .we        (we),
      .wr_addr   (dst),
      .wr_data   (wb_val),
      .clr_en    (state == S_CLR_ITER),
      .clr_idx   (cnt[REG_AW-1:0])
   );

   always_comb begin
      alu_res = b_q;
      alu_ovf = 1'b0;
      case (op)
         OP_ADD, OP_ADDI: begin
            alu_res = a_q + b_q;
            alu_ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != a_q[DATA_W-1]);
         end
         OP_SUB, OP_SUBI: begin
            alu_res = a_q - b_q;
            alu_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != a_q[DATA_W-1]);
         end
         OP_DISPLAY: alu_res = a_q;
         default:    alu_res = b_q;
      endcase
   end

   // Full signed product must fit: top DATA_W+1 bits all equal
   assign mul_hi  = acc[2*DATA_W-1:DATA_W-1];
   assign mul_ovf = !((&mul_hi) || !(|mul_hi));

   assign wb_raw = (op == OP_MUL) ? acc[DATA_W-1:0] : res_q;
   assign wb_ovf = (op == OP_MUL) ? mul_ovf : ovf_q;
   assign wb_neg = (op == OP_MUL) ? acc[2*DATA_W-1] : a_q[DATA_W-1];

`ifdef MINI_CPU_SATURATE_EN
   assign wb_val = wb_ovf ? (wb_neg ? SMIN : SMAX) : wb_raw;
`else
   assign wb_val = wb_raw;
`endif

   assign we = (state == S_WRITE) && !bad_q &&
               (op != OP_CLEAR) && (op != OP_DISPLAY);

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (instr_valid) state_nx = S_DECODE;
         S_DECODE: begin
            if (op == OP_MUL)        state_nx = S_MUL_ITER;
            else if (op == OP_CLEAR) state_nx = S_CLR_ITER;
            else                     state_nx = S_EXEC;
         end
         S_EXEC:
            state_nx = S_WRITE;
         S_MUL_ITER:
            if (cnt == LAST_MUL) state_nx = S_WRITE;
         S_CLR_ITER:
            if (cnt == LAST_CLR) state_nx = S_WRITE;
         S_WRITE:
            state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         ir           <= '0;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         ovf_q        <= 1'b0;
         bad_q        <= 1'b0;
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         cnt          <= '0;
         result       <= '0;
         result_dest  <= '0;
         result_op    <= '0;
         result_valid <= 1'b0;
         err          <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            S_IDLE:
               if (instr_valid) ir <= instr;
            S_DECODE: begin
               a_q    <= rd_data_a;
               b_q    <= use_imm ? imm_ext : rd_data_b;
               bad_q  <= bad;
               acc    <= '0;
               mcand  <= {{DATA_W{rd_data_a[DATA_W-1]}}, rd_data_a};
               mplier <= imm_ext;
               cnt    <= '0;
            end
            S_EXEC: begin
               res_q <= alu_res;
               ovf_q <= alu_ovf;
            end
            S_MUL_ITER: begin
               // The multiplier sign bit carries weight -2^(DATA_W-1)
               if (mplier[0])
                  acc <= (cnt == LAST_MUL) ? acc - mcand : acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
            end
            S_CLR_ITER:
               cnt <= cnt + 5'd1;
            S_WRITE: begin
               result_valid <= 1'b1;
               result_op    <= op;
               if (op == OP_CLEAR) begin
                  result      <= '0;
                  result_dest <= '0;
                  err         <= 1'b0;
               end else begin
                  result_dest <= dst;
                  result      <= bad_q ? '0 : wb_val;
                  if (bad_q || wb_ovf) err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mini_cpu_core.sv
// Directed bench for mini_cpu_core: latency, arithmetic, multiply,
// clear, overflow and mid-operation reset.
module tb_mini_cpu_core;

   localparam logic [2:0] LOAD = 3'b000;
   localparam logic [2:0] ADD  = 3'b001;
   localparam logic [2:0] ADDI = 3'b010;
   localparam logic [2:0] SUB  = 3'b011;
   localparam logic [2:0] SUBI = 3'b100;
   localparam logic [2:0] MUL  = 3'b101;
   localparam logic [2:0] CLR  = 3'b110;
   localparam logic [2:0] DISP = 3'b111;

   logic        CLOCK_50 = 1'b0;
   logic        rst_n;
   logic [17:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] result;
   logic [3:0]  result_dest;
   logic [2:0]  result_op;
   logic        result_valid;
   logic        busy;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   int          lat;
   logic [15:0] r_res;
   logic [3:0]  r_dst;
   logic [2:0]  r_op;
   logic        r_err;
   logic        rdy_ok;

   always #10 CLOCK_50 = ~CLOCK_50;

   mini_cpu_core #(
      .DATA_W (16),
      .NREGS  (16),
      .IMM_W  (7)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .rst_n        (rst_n),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .result       (result),
      .result_dest  (result_dest),
      .result_op    (result_op),
      .result_valid (result_valid),
      .busy         (busy),
      .err          (err)
   );

   function automatic logic [17:0] rr(input logic [2:0] o, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b);
      return {o, d, a, b, 3'b000};
   endfunction

   function automatic logic [17:0] ri(input logic [2:0] o, input logic [3:0] d,
                                      input logic [3:0] a, input logic [6:0] imm);
      return {o, d, a, imm};
   endfunction

   // Offer one instruction, then count edges until result_valid.
   // During MUL the extra pulses land on cycles 3 and 7 when ign=1.
   task automatic exec(input logic [17:0] w, input logic ign);
      int guard;
      guard = 0;
      @(negedge CLOCK_50);
      while (!instr_ready && guard < 50) begin
         @(negedge CLOCK_50);
         guard++;
      end
      instr       = w;
      instr_valid = 1'b1;
      @(posedge CLOCK_50);
      #1;
      instr_valid = 1'b0;
      lat    = -1;
      rdy_ok = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge CLOCK_50);
         if (ign && (c == 3 || c == 7)) begin
            instr       = ri(LOAD, 4'd5, 4'd0, 7'd1);
            instr_valid = 1'b1;
         end else begin
            instr_valid = 1'b0;
         end
         @(posedge CLOCK_50);
         #1;
         if (result_valid) begin
            lat   = c;
            r_res = result;
            r_dst = result_dest;
            r_op  = result_op;
            r_err = err;
            break;
         end
         if (instr_ready) rdy_ok = 1'b0;
      end
      instr_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n       = 1'b0;
      instr       = '0;
      instr_valid = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      rst_n = 1'b1;
      @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || instr_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_hs got busy=%b ready=%b want 0 1", busy, instr_ready);
      end
      n_cmp++;
      if (result !== 16'h0 || result_dest !== 4'h0 || result_op !== 3'h0) begin
         n_bad++;
         $display("FAIL reset_res got %h/%h/%h want 0/0/0", result, result_dest, result_op);
      end
      n_cmp++;
      if (result_valid !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags got valid=%b err=%b want 0 0", result_valid, err);
      end
   endtask

   task automatic test_load;
      exec(ri(LOAD, 4'd1, 4'd0, 7'b0000101), 1'b0);
      n_cmp++;
      if (lat !== 3) begin
         n_bad++;
         $display("FAIL load_lat got %0d want 3", lat);
      end
      n_cmp++;
      if (r_res !== 16'h0005 || r_dst !== 4'd1 || r_op !== LOAD) begin
         n_bad++;
         $display("FAIL load_res got %h/%h/%h want 0005/1/0", r_res, r_dst, r_op);
      end
   endtask

   task automatic test_arith;
      exec(ri(LOAD, 4'd2, 4'd0, 7'b1111101), 1'b0);
      n_cmp++;
      if (r_res !== 16'hFFFD || r_dst !== 4'd2) begin
         n_bad++;
         $display("FAIL load_neg got %h/%h want FFFD/2", r_res, r_dst);
      end
      exec(rr(ADD, 4'd3, 4'd1, 4'd2), 1'b0);
      n_cmp++;
      if (r_res !== 16'h0002 || r_op !== ADD || lat !== 3) begin
         n_bad++;
         $display("FAIL add got %h op=%h lat=%0d want 0002 op=1 lat=3", r_res, r_op, lat);
      end
      exec(ri(SUBI, 4'd4, 4'd3, 7'd4), 1'b0);
      n_cmp++;
      if (r_res !== 16'hFFFE || r_dst !== 4'd4) begin
         n_bad++;
         $display("FAIL subi got %h/%h want FFFE/4", r_res, r_dst);
      end
      exec(rr(SUB, 4'd6, 4'd1, 4'd3), 1'b0);
      n_cmp++;
      if (r_res !== 16'h0003) begin
         n_bad++;
         $display("FAIL sub got %h want 0003", r_res);
      end
      exec(ri(ADDI, 4'd7, 4'd1, 7'b1111111), 1'b0);
      n_cmp++;
      if (r_res !== 16'h0004 || r_err !== 1'b0) begin
         n_bad++;
         $display("FAIL addi got %h err=%b want 0004 err=0", r_res, r_err);
      end
   endtask

   task automatic test_mul;
      exec(ri(LOAD, 4'd1, 4'd0, 7'b1111001), 1'b0);
      exec(ri(MUL, 4'd5, 4'd1, 7'd6), 1'b1);
      n_cmp++;
      if (lat !== 18) begin
         n_bad++;
         $display("FAIL mul_lat got %0d want 18", lat);
      end
      n_cmp++;
      if (r_res !== 16'hFFD6 || r_dst !== 4'd5 || r_op !== MUL) begin
         n_bad++;
         $display("FAIL mul_res got %h/%h/%h want FFD6/5/5", r_res, r_dst, r_op);
      end
      n_cmp++;
      if (rdy_ok !== 1'b1) begin
         n_bad++;
         $display("FAIL mul_ready got ready-high-seen want never");
      end
      exec(rr(DISP, 4'd5, 4'd0, 4'd0), 1'b0);
      n_cmp++;
      if (r_res !== 16'hFFD6 || r_op !== DISP || lat !== 3) begin
         n_bad++;
         $display("FAIL mul_ignore got %h op=%h lat=%0d want FFD6 op=7 lat=3", r_res, r_op, lat);
      end
   endtask

   task automatic test_clear;
      exec(rr(CLR, 4'd0, 4'd0, 4'd0), 1'b0);
      n_cmp++;
      if (lat !== 18) begin
         n_bad++;
         $display("FAIL clr_lat got %0d want 18", lat);
      end
      n_cmp++;
      if (r_res !== 16'h0 || r_dst !== 4'd0 || r_op !== CLR || r_err !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_res got %h/%h/%h err=%b want 0/0/6 err=0",
                  r_res, r_dst, r_op, r_err);
      end
      exec(rr(DISP, 4'd5, 4'd0, 4'd0), 1'b0);
      n_cmp++;
      if (r_res !== 16'h0 || r_dst !== 4'd5) begin
         n_bad++;
         $display("FAIL clr_disp got %h/%h want 0000/5", r_res, r_dst);
      end
   endtask

   task automatic test_overflow;
      logic [15:0] exp_ovf;
`ifdef MINI_CPU_SATURATE_EN
      exp_ovf = 16'h7FFF;
`else
      exp_ovf = 16'hFC00;
`endif
      exec(ri(LOAD, 4'd1, 4'd0, 7'd63), 1'b0);
      for (int i = 0; i < 9; i++) exec(rr(ADD, 4'd1, 4'd1, 4'd1), 1'b0);
      n_cmp++;
      if (r_res !== 16'h7E00 || r_err !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_pre got %h err=%b want 7E00 err=0", r_res, r_err);
      end
      exec(rr(ADD, 4'd1, 4'd1, 4'd1), 1'b0);
      n_cmp++;
      if (r_res !== exp_ovf || r_err !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_add got %h err=%b want %h err=1", r_res, r_err, exp_ovf);
      end
      exec(rr(DISP, 4'd1, 4'd0, 4'd0), 1'b0);
      n_cmp++;
      if (r_res !== exp_ovf || r_err !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_sticky got %h err=%b want %h err=1", r_res, r_err, exp_ovf);
      end
      exec(rr(CLR, 4'd0, 4'd0, 4'd0), 1'b0);
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear got err=%b want 0", err);
      end
   endtask

   task automatic test_reset_mid;
      int seen;
      exec(ri(LOAD, 4'd5, 4'd0, 7'd9), 1'b0);
      exec(ri(LOAD, 4'd1, 4'd0, 7'd3), 1'b0);
      @(negedge CLOCK_50);
      instr       = ri(MUL, 4'd5, 4'd1, 7'd6);
      instr_valid = 1'b1;
      @(posedge CLOCK_50);
      #1;
      instr_valid = 1'b0;
      repeat (5) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      rst_n = 1'b0;
      @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || instr_ready !== 1'b1 || result_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid got busy=%b ready=%b valid=%b want 0 1 0",
                  busy, instr_ready, result_valid);
      end
      @(negedge CLOCK_50);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLOCK_50);
         #1;
         if (result_valid) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL rst_novalid got %0d pulses want 0", seen);
      end
      exec(rr(DISP, 4'd5, 4'd0, 4'd0), 1'b0);
      n_cmp++;
      if (r_res !== 16'h0 || lat !== 3) begin
         n_bad++;
         $display("FAIL rst_disp got %h lat=%0d want 0000 lat=3", r_res, lat);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_arith();
      test_mul();
      test_clear();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
